// File: rtl/l15_multichan_transducer_pkg.sv
// Shared definitions for the multi-channel L1.5 transducer.
// Holds the L1.5 field widths and PCX request / return-type codes used by the
// tile, the core-side channel request types, the transducer FSM states, and
// small helpers for byte swapping and request/return type mapping.
package l15_multichan_transducer_pkg;

  // L1.5 interface widths and encodings
  localparam int PHY_ADDR_WIDTH   = 40;
  localparam int L15_AMO_OP_WIDTH = 4;
  localparam int TLB_CSM_WIDTH    = 33;

  localparam logic [L15_AMO_OP_WIDTH-1:0] L15_AMO_OP_NONE = 4'b0000;

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;
  localparam logic [4:0] IMISS_RQ = 5'b10000;

  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [3:0] INT_RET   = 4'b0111;

  // Core-side channel request types
  typedef enum logic [1:0] {
    REQ_LOAD   = 2'd0,
    REQ_STORE  = 2'd1,
    REQ_IFETCH = 2'd2,
    REQ_RSVD   = 2'd3
  } req_type_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2
  } state_e;

  function automatic logic [63:0] bswap64(input logic [63:0] w);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = w[8*(7-b) +: 8];
    return r;
  endfunction

  // The reserved type is issued and completed as a load.
  function automatic logic [4:0] rqtype_of(input req_type_e t);
    case (t)
      REQ_STORE:  return STORE_RQ;
      REQ_IFETCH: return IMISS_RQ;
      default:    return LOAD_RQ;
    endcase
  endfunction

  function automatic logic [3:0] expected_ret(input req_type_e t);
    case (t)
      REQ_STORE:  return ST_ACK;
      REQ_IFETCH: return IFILL_RET;
      default:    return LOAD_RET;
    endcase
  endfunction

endpackage

// File: rtl/l15_multichan_transducer_if.sv
// Transducer <-> L1.5 bus.
// master: the transducer (drives the request fields, receives responses).
// slave : the L1.5 (accepts headers, returns responses).
interface l15_multichan_transducer_if;
  import l15_multichan_transducer_pkg::*;

  // Request side
  logic                        transducer_l15_val;
  logic [4:0]                  transducer_l15_rqtype;
  logic [2:0]                  transducer_l15_size;
  logic [PHY_ADDR_WIDTH-1:0]   transducer_l15_address;
  logic [63:0]                 transducer_l15_data;
  logic                        transducer_l15_nc;
  logic [L15_AMO_OP_WIDTH-1:0] transducer_l15_amo_op;
  logic                        transducer_l15_threadid;
  logic                        transducer_l15_prefetch;
  logic                        transducer_l15_invalidate_cacheline;
  logic                        transducer_l15_blockstore;
  logic                        transducer_l15_blockinitstore;
  logic [1:0]                  transducer_l15_l1rplway;
  logic [63:0]                 transducer_l15_data_next_entry;
  logic [TLB_CSM_WIDTH-1:0]    transducer_l15_csm_data;
  logic                        l15_transducer_header_ack;

  // Response side
  logic                        l15_transducer_val;
  logic [3:0]                  l15_transducer_returntype;
  logic [63:0]                 l15_transducer_data_0;
  logic [63:0]                 l15_transducer_data_1;
  logic [63:0]                 l15_transducer_data_2;
  logic [63:0]                 l15_transducer_data_3;
  logic                        transducer_l15_req_ack;

  modport master (
    output transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
           transducer_l15_address, transducer_l15_data, transducer_l15_nc,
           transducer_l15_amo_op, transducer_l15_threadid, transducer_l15_prefetch,
           transducer_l15_invalidate_cacheline, transducer_l15_blockstore,
           transducer_l15_blockinitstore, transducer_l15_l1rplway,
           transducer_l15_data_next_entry, transducer_l15_csm_data,
           transducer_l15_req_ack,
    input  l15_transducer_header_ack, l15_transducer_val, l15_transducer_returntype,
           l15_transducer_data_0, l15_transducer_data_1, l15_transducer_data_2,
           l15_transducer_data_3
  );

  modport slave (
    input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
           transducer_l15_address, transducer_l15_data, transducer_l15_nc,
           transducer_l15_amo_op, transducer_l15_threadid, transducer_l15_prefetch,
           transducer_l15_invalidate_cacheline, transducer_l15_blockstore,
           transducer_l15_blockinitstore, transducer_l15_l1rplway,
           transducer_l15_data_next_entry, transducer_l15_csm_data,
           transducer_l15_req_ack,
    output l15_transducer_header_ack, l15_transducer_val, l15_transducer_returntype,
           l15_transducer_data_0, l15_transducer_data_1, l15_transducer_data_2,
           l15_transducer_data_3
  );

endinterface

// File: rtl/l15_rr_arbiter.sv
// Round-robin arbiter.
// Ports: req_i (per-channel request), en_i (commit the current grant),
//        grant_o (one-hot), idx_o (binary index of grant), valid_o (any request).
// Search starts at ptr_q; on en_i the pointer moves to the channel after the
// granted one, so the last winner has lowest priority next time.
module l15_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  logic [IDX_W-1:0] ptr_q;

  assign valid_o = |req_i;

  always_comb begin
    int  c;
    logic found;
    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise paths that skip the assignment infer latches.
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    c       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(ptr_q) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && req_i[c]) begin
        found      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = IDX_W'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en_i && valid_o) begin
      ptr_q <= (int'(idx_o) == NUM_CH - 1) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/l15_multichan_transducer.sv
// Multi-channel core-to-L1.5 transducer.
// Ports: clk, rst_n; per-channel request bundle ch_req_* (val/type/addr/size/
//        nc/wdata) with one-hot ch_req_ack; shared completion ch_resp_val
//        (one-hot), ch_resp_err, ch_resp_data; core_int wakeup pulse;
//        l15 (master side of the L1.5 bus interface).
// One request is outstanding at a time: IDLE grants a channel and snapshots
// its request, REQ presents it until the header is accepted, WAIT_RESP waits
// for the matching return or the watchdog and completes the channel.
module l15_multichan_transducer
  import l15_multichan_transducer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter bit SWAP_BYTES = 1'b1,
  parameter int TIMEOUT_W  = 12
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CH-1:0]                ch_req_val,
  input  logic [2*NUM_CH-1:0]              ch_req_type,
  input  logic [PHY_ADDR_WIDTH*NUM_CH-1:0] ch_req_addr,
  input  logic [3*NUM_CH-1:0]              ch_req_size,
  input  logic [NUM_CH-1:0]                ch_req_nc,
  input  logic [64*NUM_CH-1:0]             ch_req_wdata,
  output logic [NUM_CH-1:0]                ch_req_ack,
  output logic [NUM_CH-1:0]                ch_resp_val,
  output logic                             ch_resp_err,
  output logic [127:0]                     ch_resp_data,
  output logic                             core_int,
  l15_multichan_transducer_if.master       l15
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WD_W  = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
  // The counter reads k-1 on the k-th WAIT_RESP edge, so firing at 2^W-2
  // completes exactly 2^W-1 cycles after the header was accepted.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((2 ** WD_W) - 2);

  state_e                    state_q;
  logic [NUM_CH-1:0]         oh_q;
  req_type_e                 type_q;
  logic [PHY_ADDR_WIDTH-1:0] addr_q;
  logic [2:0]                size_q;
  logic                      nc_q;
  logic [63:0]               wdata_q;
  logic [WD_W-1:0]           wd_q;
  logic                      l15_val_q;
  logic [NUM_CH-1:0]         ack_q;
  logic [NUM_CH-1:0]         resp_val_q;
  logic                      resp_err_q;
  logic [127:0]              resp_data_q;
  logic                      core_int_q;

  logic [NUM_CH-1:0] arb_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic              arb_en;

  assign arb_en = (state_q == ST_IDLE);

  l15_rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (ch_req_val),
    .en_i    (arb_en),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Response decode
  logic [63:0]  w0, w1, w2, w3;
  logic [127:0] ret_data;
  logic         is_int, ret_match, timeout;
  logic [63:0]  sel_wdata;

  assign w0 = SWAP_BYTES ? bswap64(l15.l15_transducer_data_0) : l15.l15_transducer_data_0;
  assign w1 = SWAP_BYTES ? bswap64(l15.l15_transducer_data_1) : l15.l15_transducer_data_1;
  assign w2 = SWAP_BYTES ? bswap64(l15.l15_transducer_data_2) : l15.l15_transducer_data_2;
  assign w3 = SWAP_BYTES ? bswap64(l15.l15_transducer_data_3) : l15.l15_transducer_data_3;

  assign is_int    = l15.l15_transducer_val && (l15.l15_transducer_returntype == INT_RET);
  assign ret_match = (l15.l15_transducer_returntype == expected_ret(type_q));
  assign timeout   = (TIMEOUT_W != 0) && (wd_q == WD_LAST);

  assign sel_wdata = ch_req_wdata[arb_idx*64 +: 64];

  always_comb begin
    ret_data = '0;
    case (type_q)
      REQ_STORE:  ret_data = '0;
      REQ_IFETCH: ret_data = addr_q[4] ? {w3, w2} : {w1, w0};
      default:    ret_data = {w1, w0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      oh_q        <= '0;
      type_q      <= REQ_LOAD;
      addr_q      <= '0;
      size_q      <= '0;
      nc_q        <= 1'b0;
      wdata_q     <= '0;
      wd_q        <= '0;
      l15_val_q   <= 1'b0;
      ack_q       <= '0;
      resp_val_q  <= '0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
      core_int_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; the pulse
      // defaults below are overridden by later assignments in the same cycle.
      ack_q      <= '0;
      resp_val_q <= '0;
      resp_err_q <= 1'b0;
      // Wakeup detection runs independently of the FSM state.
      core_int_q <= is_int && (l15.l15_transducer_data_0[17:16] == 2'b01);

      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            oh_q      <= arb_grant;
            type_q    <= req_type_e'(ch_req_type[arb_idx*2 +: 2]);
            addr_q    <= ch_req_addr[arb_idx*PHY_ADDR_WIDTH +: PHY_ADDR_WIDTH];
            size_q    <= ch_req_size[arb_idx*3 +: 3];
            nc_q      <= ch_req_nc[arb_idx];
            wdata_q   <= SWAP_BYTES ? bswap64(sel_wdata) : sel_wdata;
            l15_val_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (l15.l15_transducer_header_ack) begin
            ack_q     <= oh_q;
            wd_q      <= '0;
            l15_val_q <= 1'b0;
            state_q   <= ST_WAIT_RESP;
          end
        end

        ST_WAIT_RESP: begin
          wd_q <= wd_q + 1'b1;
          // A real (non-interrupt) return beats a same-cycle timeout.
          if (l15.l15_transducer_val && !is_int) begin
            resp_val_q  <= oh_q;
            resp_err_q  <= !ret_match;
            resp_data_q <= ret_match ? ret_data : '0;
            state_q     <= ST_IDLE;
          end else if (timeout) begin
            resp_val_q  <= oh_q;
            resp_err_q  <= 1'b1;
            resp_data_q <= '0;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ch_req_ack   = ack_q;
  assign ch_resp_val  = resp_val_q;
  assign ch_resp_err  = resp_err_q;
  assign ch_resp_data = resp_data_q;
  assign core_int     = core_int_q;

  assign l15.transducer_l15_val                  = l15_val_q;
  assign l15.transducer_l15_rqtype               = rqtype_of(type_q);
  assign l15.transducer_l15_size                 = size_q;
  assign l15.transducer_l15_address              = addr_q;
  assign l15.transducer_l15_data                 = wdata_q;
  assign l15.transducer_l15_nc                   = nc_q;
  assign l15.transducer_l15_amo_op               = L15_AMO_OP_NONE;
  assign l15.transducer_l15_threadid             = 1'b0;
  assign l15.transducer_l15_prefetch             = 1'b0;
  assign l15.transducer_l15_invalidate_cacheline = 1'b0;
  assign l15.transducer_l15_blockstore           = 1'b0;
  assign l15.transducer_l15_blockinitstore       = 1'b0;
  assign l15.transducer_l15_l1rplway             = '0;
  assign l15.transducer_l15_data_next_entry      = '0;
  assign l15.transducer_l15_csm_data             = '0;
  // Every L1.5 return is consumed immediately, including dropped ones.
  assign l15.transducer_l15_req_ack              = l15.l15_transducer_val;

endmodule

// File: tb/tb_l15_multichan_transducer.sv
// Self-checking bench for l15_multichan_transducer (NUM_CH=4, SWAP_BYTES=1,
// TIMEOUT_W=4). Expected completions are queued when a response is scheduled
// and popped by a monitor when ch_resp_val fires.
module tb_l15_multichan_transducer;
  import l15_multichan_transducer_pkg::*;

  localparam int NCH = 4;
  localparam int PA  = PHY_ADDR_WIDTH;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NCH-1:0]      ch_req_val;
  logic [2*NCH-1:0]    ch_req_type;
  logic [PA*NCH-1:0]   ch_req_addr;
  logic [3*NCH-1:0]    ch_req_size;
  logic [NCH-1:0]      ch_req_nc;
  logic [64*NCH-1:0]   ch_req_wdata;
  logic [NCH-1:0]      ch_req_ack;
  logic [NCH-1:0]      ch_resp_val;
  logic                ch_resp_err;
  logic [127:0]        ch_resp_data;
  logic                core_int;

  l15_multichan_transducer_if l15_bus();

  l15_multichan_transducer #(.NUM_CH(NCH), .SWAP_BYTES(1'b1), .TIMEOUT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_req_val   (ch_req_val),
    .ch_req_type  (ch_req_type),
    .ch_req_addr  (ch_req_addr),
    .ch_req_size  (ch_req_size),
    .ch_req_nc    (ch_req_nc),
    .ch_req_wdata (ch_req_wdata),
    .ch_req_ack   (ch_req_ack),
    .ch_resp_val  (ch_resp_val),
    .ch_resp_err  (ch_resp_err),
    .ch_resp_data (ch_resp_data),
    .core_int     (core_int),
    .l15          (l15_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] oh;
    logic           err;
    logic [127:0]   data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] swap_model(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = w[8*i +: 8];
    return r;
  endfunction

  // Completion monitor
  always @(negedge clk) begin
    if (rst_n && (ch_resp_val !== '0)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_resp val=%b err=%b", ch_resp_val, ch_resp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ch_resp_val !== e.oh || ch_resp_err !== e.err || ch_resp_data !== e.data) begin
          errors++;
          $display("FAIL resp got val=%b err=%b data=%h want val=%b err=%b data=%h",
                   ch_resp_val, ch_resp_err, ch_resp_data, e.oh, e.err, e.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic apply_reset();
    rst_n        = 1'b0;
    ch_req_val   = '0;
    ch_req_type  = '0;
    ch_req_addr  = '0;
    ch_req_size  = '0;
    ch_req_nc    = '0;
    ch_req_wdata = '0;
    l15_bus.l15_transducer_header_ack = 1'b0;
    l15_bus.l15_transducer_val        = 1'b0;
    l15_bus.l15_transducer_returntype = 4'h0;
    l15_bus.l15_transducer_data_0     = '0;
    l15_bus.l15_transducer_data_1     = '0;
    l15_bus.l15_transducer_data_2     = '0;
    l15_bus.l15_transducer_data_3     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input int ch, input logic [1:0] typ, input logic [PA-1:0] addr,
                       input logic [63:0] wd);
    ch_req_type[2*ch +: 2]   = typ;
    ch_req_addr[PA*ch +: PA] = addr;
    ch_req_size[3*ch +: 3]   = 3'b011;
    ch_req_nc[ch]            = 1'b0;
    ch_req_wdata[64*ch +: 64] = wd;
    ch_req_val[ch]           = 1'b1;
  endtask

  task automatic wait_l15_val(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (l15_bus.transducer_l15_val === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL l15_val_wait got 0 want 1");
    end
  endtask

  // Accept the header after dly cycles; checks the one-cycle ack pulse.
  task automatic header_handshake(input int ch, input int dly);
    logic [NCH-1:0] oh;
    oh = NCH'(1) << ch;
    repeat (dly) @(negedge clk);
    l15_bus.l15_transducer_header_ack = 1'b1;
    @(negedge clk);
    l15_bus.l15_transducer_header_ack = 1'b0;
    checks++;
    if (ch_req_ack !== oh) begin
      errors++; $display("FAIL req_ack got %b want %b", ch_req_ack, oh);
    end
    ch_req_val[ch] = 1'b0;
    @(negedge clk);
    checks++;
    if (ch_req_ack !== '0) begin
      errors++; $display("FAIL req_ack_pulse got %b want 0", ch_req_ack);
    end
  endtask

  task automatic respond(input int dly, input logic [3:0] rt, input logic [63:0] d0,
                         input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3);
    repeat (dly) @(negedge clk);
    l15_bus.l15_transducer_returntype = rt;
    l15_bus.l15_transducer_data_0     = d0;
    l15_bus.l15_transducer_data_1     = d1;
    l15_bus.l15_transducer_data_2     = d2;
    l15_bus.l15_transducer_data_3     = d3;
    l15_bus.l15_transducer_val        = 1'b1;
    @(negedge clk);
    l15_bus.l15_transducer_val        = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic push_exp(input int ch, input logic err, input logic [127:0] data);
    exp_t e;
    e.oh = NCH'(1) << ch; e.err = err; e.data = data;
    sb.push_back(e);
  endtask

  // Full transaction for a request already raised with issue().
  task automatic serve(input int ch, input logic [1:0] typ, input logic [PA-1:0] addr,
                       input logic [63:0] wd, input int ack_dly, input int resp_dly,
                       input logic [3:0] rt, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [63:0] d2, input logic [63:0] d3,
                       input logic exp_err, input logic [127:0] exp_data);
    bit ok;
    logic [4:0] exp_rq;
    exp_rq = (typ == 2'd1) ? 5'b00001 : (typ == 2'd2) ? 5'b10000 : 5'b00000;
    wait_l15_val(ok);
    if (!ok) return;
    checks++;
    if (l15_bus.transducer_l15_address !== addr) begin
      errors++; $display("FAIL grant_addr ch%0d got %h want %h", ch, l15_bus.transducer_l15_address, addr);
    end
    checks++;
    if (l15_bus.transducer_l15_rqtype !== exp_rq) begin
      errors++; $display("FAIL rqtype got %b want %b", l15_bus.transducer_l15_rqtype, exp_rq);
    end
    if (typ == 2'd1) begin
      checks++;
      if (l15_bus.transducer_l15_data !== swap_model(wd)) begin
        errors++; $display("FAIL st_data got %h want %h", l15_bus.transducer_l15_data, swap_model(wd));
      end
    end
    header_handshake(ch, ack_dly);
    push_exp(ch, exp_err, exp_data);
    respond(resp_dly, rt, d0, d1, d2, d3);
    drain();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (l15_bus.transducer_l15_val !== 1'b0 || ch_req_ack !== '0 || ch_resp_val !== '0 ||
        core_int !== 1'b0) begin
      errors++; $display("FAIL reset_outputs val=%b ack=%b resp=%b int=%b want all 0",
                         l15_bus.transducer_l15_val, ch_req_ack, ch_resp_val, core_int);
    end
    checks++;
    if (dut.state_q !== ST_IDLE || dut.u_arb.ptr_q !== 2'd0) begin
      errors++; $display("FAIL reset_state got %0d/%0d want IDLE/0", dut.state_q, dut.u_arb.ptr_q);
    end
  endtask

  task automatic test_single_load();
    apply_reset();
    issue(0, 2'd0, 40'h80_0000_1230, 64'h0);
    @(negedge clk);
    checks++;
    if (l15_bus.transducer_l15_val !== 1'b1) begin
      errors++; $display("FAIL grant_latency got %b want 1", l15_bus.transducer_l15_val);
    end
    serve(0, 2'd0, 40'h80_0000_1230, 64'h0, 3, 2, LOAD_RET,
          64'h0102030405060708, 64'h1112131415161718, 64'h0, 64'h0,
          1'b0, {64'h1817161514131211, 64'h0807060504030201});
  endtask

  task automatic test_round_robin();
    logic [63:0] d;
    apply_reset();
    for (int c = 0; c < NCH; c++) issue(c, 2'd0, 40'h10_0000_0000 + PA'(c * 64), 64'h0);
    for (int c = 0; c < NCH; c++) begin
      d = 64'hA0A1A2A3A4A5A600 + 64'(c);
      serve(c, 2'd0, 40'h10_0000_0000 + PA'(c * 64), 64'h0, 0, 1, LOAD_RET,
            d, ~d, 64'h0, 64'h0, 1'b0, {swap_model(~d), swap_model(d)});
    end
    issue(2, 2'd0, 40'h20_0000_0200, 64'h0);
    issue(0, 2'd0, 40'h20_0000_0000, 64'h0);
    serve(0, 2'd0, 40'h20_0000_0000, 64'h0, 1, 0, LOAD_RET,
          64'h1, 64'h2, 64'h0, 64'h0, 1'b0, {swap_model(64'h2), swap_model(64'h1)});
    serve(2, 2'd0, 40'h20_0000_0200, 64'h0, 1, 0, LOAD_RET,
          64'h3, 64'h4, 64'h0, 64'h0, 1'b0, {swap_model(64'h4), swap_model(64'h3)});
  endtask

  task automatic test_store();
    bit ok;
    issue(1, 2'd1, 40'h80_0000_2000, 64'h1122334455667788);
    wait_l15_val(ok);
    checks++;
    if (l15_bus.transducer_l15_data !== 64'h8877665544332211 ||
        l15_bus.transducer_l15_rqtype !== STORE_RQ) begin
      errors++; $display("FAIL store_req got %h/%b want 8877665544332211/00001",
                         l15_bus.transducer_l15_data, l15_bus.transducer_l15_rqtype);
    end
    serve(1, 2'd1, 40'h80_0000_2000, 64'h1122334455667788, 1, 2, ST_ACK,
          64'hDEAD, 64'hBEEF, 64'h0, 64'h0, 1'b0, 128'h0);
    // Wrong return type for a store completes with an error.
    issue(1, 2'd1, 40'h80_0000_2008, 64'hCAFEF00D12345678);
    serve(1, 2'd1, 40'h80_0000_2008, 64'hCAFEF00D12345678, 0, 1, LOAD_RET,
          64'h55, 64'h66, 64'h0, 64'h0, 1'b1, 128'h0);
  endtask

  task automatic test_ifetch();
    logic [63:0] d0, d1, d2, d3;
    d0 = 64'h0011223344556677; d1 = 64'h8899AABBCCDDEEFF;
    d2 = 64'h0123456789ABCDEF; d3 = 64'hFEDCBA9876543210;
    issue(2, 2'd2, 40'h80_0000_0010, 64'h0);
    serve(2, 2'd2, 40'h80_0000_0010, 64'h0, 0, 3, IFILL_RET, d0, d1, d2, d3,
          1'b0, {swap_model(d3), swap_model(d2)});
    issue(2, 2'd2, 40'h80_0000_0020, 64'h0);
    serve(2, 2'd2, 40'h80_0000_0020, 64'h0, 2, 0, IFILL_RET, d0, d1, d2, d3,
          1'b0, {swap_model(d1), swap_model(d0)});
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    issue(3, 2'd0, 40'h80_0000_3000, 64'h0);
    wait_l15_val(ok);
    l15_bus.l15_transducer_header_ack = 1'b1;
    @(negedge clk);
    l15_bus.l15_transducer_header_ack = 1'b0;
    checks++;
    if (ch_req_ack !== 4'b1000) begin
      errors++; $display("FAIL to_req_ack got %b want 1000", ch_req_ack);
    end
    ch_req_val[3] = 1'b0;
    push_exp(3, 1'b1, 128'h0);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ch_resp_val !== '0) begin k = i; break; end
    end
    checks++;
    if (k != 15) begin
      errors++; $display("FAIL timeout_cycles got %0d want 15", k);
    end
    checks++;
    if (dut.state_q !== ST_IDLE || l15_bus.transducer_l15_val !== 1'b0) begin
      errors++; $display("FAIL timeout_idle state=%0d val=%b want IDLE/0",
                         dut.state_q, l15_bus.transducer_l15_val);
    end
    drain();
    // Response arriving on the same edge the watchdog expires: response wins.
    issue(0, 2'd0, 40'h80_0000_3100, 64'h0);
    serve(0, 2'd0, 40'h80_0000_3100, 64'h0, 0, 13, LOAD_RET,
          64'h7, 64'h9, 64'h0, 64'h0, 1'b0, {swap_model(64'h9), swap_model(64'h7)});
  endtask

  task automatic test_interrupt();
    bit ok;
    issue(3, 2'd0, 40'h80_0000_4000, 64'h0);
    wait_l15_val(ok);
    header_handshake(3, 1);
    push_exp(3, 1'b0, {swap_model(64'hB), swap_model(64'hA)});
    l15_bus.l15_transducer_returntype = INT_RET;
    l15_bus.l15_transducer_data_0     = 64'h0000_0000_0001_0000;
    l15_bus.l15_transducer_val        = 1'b1;
    #1;
    checks++;
    if (l15_bus.transducer_l15_req_ack !== 1'b1) begin
      errors++; $display("FAIL req_ack_comb got %b want 1", l15_bus.transducer_l15_req_ack);
    end
    @(negedge clk);
    l15_bus.l15_transducer_val = 1'b0;
    checks++;
    if (core_int !== 1'b1) begin
      errors++; $display("FAIL core_int_pulse got %b want 1", core_int);
    end
    @(negedge clk);
    checks++;
    if (core_int !== 1'b0) begin
      errors++; $display("FAIL core_int_width got %b want 0", core_int);
    end
    // Other interrupt codes are ignored.
    l15_bus.l15_transducer_data_0 = 64'h0000_0000_0002_0000;
    l15_bus.l15_transducer_val    = 1'b1;
    @(negedge clk);
    l15_bus.l15_transducer_val = 1'b0;
    checks++;
    if (core_int !== 1'b0) begin
      errors++; $display("FAIL core_int_code got %b want 0", core_int);
    end
    respond(0, LOAD_RET, 64'hA, 64'hB, 64'h0, 64'h0);
    drain();
    // Stray load return while idle is dropped.
    respond(1, LOAD_RET, 64'h1, 64'h2, 64'h0, 64'h0);
    @(negedge clk);
    checks++;
    if (ch_resp_val !== '0 || dut.state_q !== ST_IDLE) begin
      errors++; $display("FAIL idle_drop resp=%b state=%0d want 0/IDLE", ch_resp_val, dut.state_q);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    issue(1, 2'd1, 40'h80_0000_5000, 64'h1);
    wait_l15_val(ok);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (l15_bus.transducer_l15_val !== 1'b0 || ch_req_ack !== '0 || ch_resp_val !== '0 ||
        core_int !== 1'b0 || dut.state_q !== ST_IDLE) begin
      errors++; $display("FAIL async_reset val=%b ack=%b resp=%b int=%b state=%0d want 0",
                         l15_bus.transducer_l15_val, ch_req_ack, ch_resp_val, core_int, dut.state_q);
    end
    ch_req_val = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (l15_bus.transducer_l15_val !== 1'b0 || ch_resp_val !== '0) begin
      errors++; $display("FAIL post_reset val=%b resp=%b want 0", l15_bus.transducer_l15_val, ch_resp_val);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_round_robin();
    test_store();
    test_ifetch();
    test_timeout();
    test_interrupt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
